// File: rtl/uart_tx_cfg_if.sv
// Push-side handshake between the peripheral register block and the transmitter FIFO.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with runtime parity / stop-bit selection and a clock-enable baud counter.
module uart_tx_cfg #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_cfg_if.slave                bus,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        two_stop,
  output logic                        busy,
  output logic                        txdone,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        tx
);

  localparam int unsigned DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned BW  = $clog2(DATA_BITS);

  // Elaboration-time parameter legality
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLOCK_FREQ / BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_cfg: DATA_BITS must be within 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [BW-1:0]        bit_idx, bit_idx_nx;
  logic                 stop_idx, stop_idx_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 par_en_q, par_en_nx;
  logic                 par_bit_q, par_bit_nx;
  logic                 two_stop_q, two_stop_nx;
  logic                 tx_nx, done_nx, busy_nx;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level_nx;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop, has_data;
  logic                 bit_end, last_data, last_stop, frame_end;

  assign head      = mem[rd_ptr];
  assign has_data  = (fifo_level != '0);
  assign push      = bus.tx_valid && bus.tx_ready;
  assign bit_end   = (cnt == CW'(DIV - 1));
  assign last_data = (bit_idx == BW'(DATA_BITS - 1));
  assign last_stop = (stop_idx == two_stop_q);
  assign frame_end = (state == S_STOP) && bit_end && last_stop;
  // A frame starts from IDLE or directly from the last stop bit when data is waiting
  assign pop       = has_data && ((state == S_IDLE) || frame_end);
  assign level_nx  = fifo_level + LW'(push) - LW'(pop);

  // FIFO storage; no reset needed since occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      bus.tx_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level   <= level_nx;
      bus.tx_ready <= (level_nx != LW'(FIFO_DEPTH));
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (pop) state_nx = S_START;
      S_START:  if (bit_end) state_nx = S_DATA;
      S_DATA:   if (bit_end && last_data) state_nx = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP:   if (frame_end) state_nx = pop ? S_START : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output / datapath next values; tx only moves on bit-period boundaries
  always_comb begin
    cnt_nx      = ((state == S_IDLE) || bit_end) ? '0 : cnt + CW'(1);
    tx_nx       = tx;
    shift_nx    = shift;
    bit_idx_nx  = bit_idx;
    stop_idx_nx = stop_idx;
    par_en_nx   = par_en_q;
    par_bit_nx  = par_bit_q;
    two_stop_nx = two_stop_q;
    done_nx     = 1'b0;
    busy_nx     = (state_nx != S_IDLE);
    case (state)
      S_START: if (bit_end) tx_nx = shift[0];
      S_DATA: begin
        if (bit_end) begin
          if (last_data) begin
            tx_nx = par_en_q ? par_bit_q : 1'b1;
          end else begin
            tx_nx      = shift[1];
            shift_nx   = shift >> 1;
            bit_idx_nx = bit_idx + BW'(1);
          end
        end
      end
      S_PARITY: if (bit_end) tx_nx = 1'b1;
      S_STOP: begin
        if (bit_end && !last_stop) stop_idx_nx = 1'b1;
        if (frame_end) begin
          done_nx = 1'b1;
          tx_nx   = 1'b1;
        end
      end
      default: ;
    endcase
    // Frame start: load payload and freeze the line configuration for this frame
    if (pop) begin
      shift_nx    = head;
      par_en_nx   = parity_en;
      par_bit_nx  = (^head) ^ parity_odd;
      two_stop_nx = two_stop;
      bit_idx_nx  = '0;
      stop_idx_nx = 1'b0;
      tx_nx       = 1'b0;
      cnt_nx      = '0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx         <= 1'b1;
      txdone     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      bit_idx    <= bit_idx_nx;
      stop_idx   <= stop_idx_nx;
      shift      <= shift_nx;
      par_en_q   <= par_en_nx;
      par_bit_q  <= par_bit_nx;
      two_stop_q <= two_stop_nx;
      tx         <= tx_nx;
      txdone     <= done_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench: serial decoder + scoreboard on the 8-bit build, plus 5- and 9-bit builds.
module tb_uart_tx_cfg;

  localparam int unsigned CF    = 1000000;
  localparam int unsigned BR    = 100000;
  localparam int          DIV   = 10;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) bus8 ();
  uart_tx_cfg_if #(.DATA_BITS(5)) bus5 ();
  uart_tx_cfg_if #(.DATA_BITS(9)) bus9 ();

  logic       parity_en, parity_odd, two_stop;
  logic       busy, txdone, tx;
  logic [2:0] fifo_level;
  logic       busy5, txdone5, tx5, busy9, txdone9, tx9;
  logic [2:0] fifo_level5, fifo_level9;

  uart_tx_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .parity_en(parity_en), .parity_odd(parity_odd),
    .two_stop(two_stop), .busy(busy), .txdone(txdone), .fifo_level(fifo_level), .tx(tx));

  uart_tx_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(5), .FIFO_DEPTH(DEPTH)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5), .parity_en(1'b0), .parity_odd(1'b0),
    .two_stop(1'b0), .busy(busy5), .txdone(txdone5), .fifo_level(fifo_level5), .tx(tx5));

  uart_tx_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(9), .FIFO_DEPTH(DEPTH)) dut9 (
    .clk(clk), .rst_n(rst_n), .bus(bus9), .parity_en(1'b0), .parity_odd(1'b0),
    .two_stop(1'b0), .busy(busy9), .txdone(txdone9), .fifo_level(fifo_level9), .tx(tx9));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted words queued in order; config captured as seen at each edge
  logic [7:0] exp_q[$];
  logic [2:0] cfg_q;
  always @(posedge clk) cfg_q <= {parity_en, parity_odd, two_stop};
  always @(posedge clk) if (rst_n && bus8.tx_valid && bus8.tx_ready) exp_q.push_back(bus8.tx_data);

  // Serial decoder state
  logic        in_frame = 1'b0;
  logic [15:0] ebits;
  int          cyc, nlen;
  int          frames = 0;
  int          b2b = 0;

  task automatic start_frame();
    logic [7:0] d;
    logic       pe, po, ts;
    {pe, po, ts} = cfg_q;
    d = 8'h00;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_start: got a start bit, expected idle line");
    end else begin
      d = exp_q.pop_front();
    end
    ebits    = 16'hFFFF;
    ebits[0] = 1'b0;
    for (int i = 0; i < 8; i++) ebits[1+i] = d[i];
    if (pe) ebits[9] = (^d) ^ po;
    nlen     = DIV * (10 + int'(pe) + int'(ts));
    cyc      = 0;
    in_frame = 1'b1;
    chk("busy_at_start", 32'(busy), 32'd1);
  endtask

  // Decoder samples each bit mid-period and checks txdone lands exactly N cycles after tx falls
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      exp_q.delete();
    end else if (!in_frame) begin
      if (txdone !== 1'b0) chk("spurious_txdone", 32'(txdone), 32'd0);
      if (tx === 1'b0) start_frame();
    end else begin
      cyc++;
      if (cyc < nlen) begin
        if (cyc % DIV == DIV / 2)
          chk($sformatf("frame%0d_bit%0d", frames, cyc / DIV), 32'(tx), 32'(ebits[cyc / DIV]));
        if (txdone !== 1'b0) chk($sformatf("frame%0d_early_txdone", frames), 32'(txdone), 32'd0);
      end else begin
        chk($sformatf("frame%0d_txdone_at_end", frames), 32'(txdone), 32'd1);
        frames++;
        in_frame = 1'b0;
        if (tx === 1'b0) begin
          b2b++;
          start_frame();
        end else begin
          chk($sformatf("frame%0d_busy_low", frames), 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic push_word(input logic [7:0] d, output int waited);
    waited         = 0;
    bus8.tx_data   = d;
    bus8.tx_valid  = 1'b1;
    while (bus8.tx_ready !== 1'b1 && waited < 2000) begin
      tick(1);
      waited++;
    end
    if (waited >= 2000) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got tx_ready low for 2000 cycles, expected acceptance");
    end
    tick(1);
    bus8.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy !== 1'b0 || fifo_level !== 3'd0 || in_frame) && k < 5000) begin
      tick(1);
      k++;
    end
    if (k >= 5000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b level=%0d, expected idle", busy, fifo_level);
    end
    tick(2);
  endtask

  function automatic logic wtx(input int sel);
    return (sel == 5) ? tx5 : tx9;
  endfunction

  function automatic logic wdone(input int sel);
    return (sel == 5) ? txdone5 : txdone9;
  endfunction

  // Hand-checked frame on the 5- or 9-bit build: payload LSB first and total length
  task automatic wide_frame(input int sel, input logic [8:0] d, input int nb);
    int c;
    if (sel == 5) begin bus5.tx_data = d[4:0]; bus5.tx_valid = 1'b1; end
    else          begin bus9.tx_data = d;      bus9.tx_valid = 1'b1; end
    tick(1);
    bus5.tx_valid = 1'b0;
    bus9.tx_valid = 1'b0;
    c = 0;
    while (wtx(sel) !== 1'b0 && c < 20) begin tick(1); c++; end
    chk($sformatf("w%0d_fall", sel), 32'(wtx(sel)), 32'd0);
    tick(DIV / 2);
    chk($sformatf("w%0d_start", sel), 32'(wtx(sel)), 32'd0);
    for (int i = 0; i < nb; i++) begin
      tick(DIV);
      chk($sformatf("w%0d_bit%0d", sel, i), 32'(wtx(sel)), 32'(d[i]));
    end
    tick(DIV);
    chk($sformatf("w%0d_stop", sel), 32'(wtx(sel)), 32'd1);
    c = DIV / 2 + (nb + 1) * DIV;
    while (wdone(sel) !== 1'b1 && c < 400) begin tick(1); c++; end
    chk($sformatf("w%0d_len", sel), 32'(c), 32'((nb + 2) * DIV));
    tick(1);
    chk($sformatf("w%0d_busy_low", sel), 32'(sel == 5 ? busy5 : busy9), 32'd0);
    chk($sformatf("w%0d_level", sel), 32'(sel == 5 ? fifo_level5 : fifo_level9), 32'd0);
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic [2:0] exp_level;
    logic       exp_busy;
  } vec_t;

  vec_t vt[7];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w, f0, b0;
    vt[0] = '{1'b1, 8'hA0, 1'b1, 3'd1, 1'b0};
    vt[1] = '{1'b1, 8'hA1, 1'b1, 3'd1, 1'b1};
    vt[2] = '{1'b1, 8'hA2, 1'b1, 3'd2, 1'b1};
    vt[3] = '{1'b1, 8'hA3, 1'b1, 3'd3, 1'b1};
    vt[4] = '{1'b1, 8'hA4, 1'b0, 3'd4, 1'b1};
    vt[5] = '{1'b1, 8'hA5, 1'b0, 3'd4, 1'b1};
    vt[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1};

    rst_n = 1'b0;
    bus8.tx_valid = 1'b0; bus8.tx_data = '0;
    bus5.tx_valid = 1'b0; bus5.tx_data = '0;
    bus9.tx_valid = 1'b0; bus9.tx_data = '0;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    tick(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txdone", 32'(txdone), 32'd0);
    chk("rst_ready", 32'(bus8.tx_ready), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    // 8N1 0x55 with push-to-line latency
    bus8.tx_data = 8'h55; bus8.tx_valid = 1'b1;
    tick(1);
    bus8.tx_valid = 1'b0;
    chk("lat_level_after_push", 32'(fifo_level), 32'd1);
    chk("lat_tx_still_high", 32'(tx), 32'd1);
    chk("lat_busy_low", 32'(busy), 32'd0);
    tick(1);
    chk("lat_level_after_pop", 32'(fifo_level), 32'd0);
    chk("lat_tx_fell", 32'(tx), 32'd0);
    chk("lat_busy_high", 32'(busy), 32'd1);
    wait_idle();
    chk("frames_8n1", 32'(frames), 32'd1);

    // Parity even / odd, two stop bits, then mid-frame config change
    f0 = frames;
    parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
    push_word(8'h07, w); wait_idle();
    parity_odd = 1'b1;
    push_word(8'h07, w); wait_idle();
    two_stop = 1'b1;
    push_word(8'h07, w); wait_idle();
    parity_odd = 1'b0;
    push_word(8'h07, w);
    tick(40);
    parity_en = 1'b0; parity_odd = 1'b1; two_stop = 1'b0;
    wait_idle();
    chk("frames_parity", 32'(frames - f0), 32'd4);
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;

    // FIFO fill and back-pressure, table driven
    f0 = frames; b0 = b2b;
    for (int i = 0; i < 7; i++) begin
      bus8.tx_valid = vt[i].valid;
      bus8.tx_data  = vt[i].data;
      tick(1);
      chk($sformatf("tbl%0d_ready", i), 32'(bus8.tx_ready), 32'(vt[i].exp_ready));
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(vt[i].exp_level));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
    end
    push_word(8'hA5, w);
    chk("full_push_waited", 32'(w >= 90), 32'd1);
    chk("full_level_refilled", 32'(fifo_level), 32'd4);
    chk("full_ready_low", 32'(bus8.tx_ready), 32'd0);
    wait_idle();
    chk("fifo_frames", 32'(frames - f0), 32'd6);
    chk("fifo_contiguous", 32'(b2b - b0), 32'd5);

    // Wrap-around streaming with random gaps
    f0 = frames;
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      push_word(8'($urandom), w);
      tick($urandom_range(0, 60));
    end
    wait_idle();
    chk("wrap_frames", 32'(frames - f0), 32'(3 * DEPTH));

    // Reset during data bit 3 with a second word queued
    f0 = frames;
    push_word(8'hA3, w);
    push_word(8'h11, w);
    w = 0;
    while (tx !== 1'b0 && w < 50) begin tick(1); w++; end
    tick(4 * DIV + DIV / 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_txdone", 32'(txdone), 32'd0);
    tick(3);
    chk("midrst_txdone_held", 32'(txdone), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(2);
    chk("midrst_no_frame", 32'(frames - f0), 32'd0);
    push_word(8'hC3, w);
    wait_idle();
    chk("midrst_recovered", 32'(frames - f0), 32'd1);

    // Narrow and wide builds
    wide_frame(5, 9'h015, 5);
    wide_frame(9, 9'h1A5, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
